// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the MMIO read path.
// First-word fall-through storage with sticky overrun, watermark and character-timeout interrupts.
module uart_rx_fifo #(
  parameter  int DEPTH          = 16,
  parameter  int WIDTH          = 8,
  parameter  int TIMEOUT_CYCLES = 10000,
  localparam int CW             = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             pop,
  input  logic             flush,
  input  logic [CW-1:0]    thresh,
  input  logic             clear_overrun,
  output logic [CW-1:0]    count,
  output logic             overrun,
  output logic             irq_level,
  output logic             irq_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [TW-1:0]    tcnt;

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic drop;
  logic tcnt_clr;

  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign in_ready  = !full || (pop && out_valid);
  assign out_data  = mem[rd_ptr];

  // flush wins over both sides: the byte is discarded and is not counted as an overrun
  assign do_push  = in_valid && in_ready && !flush;
  assign do_pop   = pop && out_valid && !flush;
  assign drop     = in_valid && !in_ready && !flush;
  assign tcnt_clr = do_push || do_pop || flush || empty;

  assign irq_level = (thresh != '0) && (count >= thresh);

  // NOTE: storage has no reset; out_data is don't-care while empty, so the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Set beats clear when a drop and clear_overrun coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

  // irq_timeout rises on the same edge the idle counter reaches TIMEOUT_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      irq_timeout <= 1'b0;
    end else begin
      if (tcnt_clr)          tcnt <= '0;
      else if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;

      if (flush || do_pop)                irq_timeout <= 1'b0;
      else if (!tcnt_clr && tcnt == T_LAST) irq_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte queue models the FIFO contents and
// is compared against out_data on every pop; flags and interrupts are checked per scenario.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int TOUT  = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             pop;
  logic             flush;
  logic [CW-1:0]    thresh;
  logic             clear_overrun;
  logic [CW-1:0]    count;
  logic             overrun;
  logic             irq_level;
  logic             irq_timeout;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovr;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .pop(pop), .flush(flush), .thresh(thresh),
    .clear_overrun(clear_overrun), .count(count), .overrun(overrun),
    .irq_level(irq_level), .irq_timeout(irq_timeout)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; scoreboard pushes accepted bytes and compares popped ones.
  task automatic xfer(input logic pv, input logic [WIDTH-1:0] pd, input logic pp);
    logic             acc;
    logic             rdy;
    logic [WIDTH-1:0] exp;
    in_valid = pv; in_data = pd; pop = pp;
    #1;
    rdy = (exp_q.size() < DEPTH) || (pp && exp_q.size() > 0);
    acc = pv && rdy;
    checks++;
    if (in_ready !== rdy) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b", in_ready, rdy);
    end
    if (pp && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin
        failures++;
        $display("FAIL pop_data: got %02h expected %02h", out_data, exp);
      end
    end
    if (acc) exp_q.push_back(pd);
    if (pv && !acc) m_ovr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; pop = 1'b0;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (count !== CW'(exp_q.size()) || out_valid !== (exp_q.size() > 0) || overrun !== m_ovr) begin
      failures++;
      $display("FAIL %s: got count=%0d valid=%b ovr=%b expected count=%0d valid=%b ovr=%b",
               name, count, out_valid, overrun, exp_q.size(), exp_q.size() > 0, m_ovr);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) xfer(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overrun !== 1'b0 ||
        irq_level !== 1'b0 || irq_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset: got count=%0d valid=%b rdy=%b ovr=%b lvl=%b tout=%b expected 0 0 1 0 0 0",
               count, out_valid, in_ready, overrun, irq_level, irq_timeout);
    end
  endtask

  task automatic test_ordering();
    xfer(1'b1, 8'h11, 1'b0); check_state("order_push1");
    xfer(1'b1, 8'h22, 1'b0); check_state("order_push2");
    xfer(1'b1, 8'h33, 1'b0); check_state("order_push3");
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, '0, 1'b1); check_state("order_pop");
    end
    // pop while empty must be harmless
    xfer(1'b0, '0, 1'b1); check_state("order_pop_empty");
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, WIDTH'(i), 1'b0);
    check_state("full_count");
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b expected 0", in_ready);
    end
    xfer(1'b1, 8'hAA, 1'b0); check_state("overrun_drop");
    drain(); check_state("full_drained");
    clear_overrun = 1'b1; m_ovr = 1'b0;
    @(posedge clk); #1; clear_overrun = 1'b0;
    check_state("clear_overrun");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, WIDTH'(i), 1'b0);
    xfer(1'b1, 8'hBB, 1'b1); check_state("full_push_pop");
    drain(); check_state("b2b_drained");
    // sustained one-in/one-out
    xfer(1'b1, 8'hC0, 1'b0);
    for (int i = 1; i < 10; i++) xfer(1'b1, WIDTH'(8'hC0 + i), 1'b1);
    check_state("stream_level");
    drain();
  endtask

  task automatic test_wrap_watermark();
    logic pv, pp;
    thresh = CW'(4);
    for (int i = 0; i < 40; i++) begin
      pv = (i < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      pp = (i < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      xfer(pv, WIDTH'(8'h40 + i), pp);
      checks++;
      if (irq_level !== (exp_q.size() >= 4)) begin
        failures++;
        $display("FAIL irq_level_t4: got %b expected %b (count=%0d)", irq_level, exp_q.size() >= 4, exp_q.size());
      end
    end
    check_state("wrap_state");
    drain();
    thresh = '0;
    for (int i = 0; i < 6; i++) xfer(1'b1, WIDTH'(8'h60 + i), 1'b0);
    checks++;
    if (irq_level !== 1'b0) begin
      failures++;
      $display("FAIL irq_level_t0: got %b expected 0", irq_level);
    end
    thresh = CW'(DEPTH + 1);
    for (int i = 6; i < DEPTH; i++) xfer(1'b1, WIDTH'(8'h60 + i), 1'b0);
    #1;
    checks++;
    if (irq_level !== 1'b0) begin
      failures++;
      $display("FAIL irq_level_big: got %b expected 0", irq_level);
    end
    thresh = CW'(DEPTH);
    #1;
    checks++;
    if (irq_level !== 1'b1) begin
      failures++;
      $display("FAIL irq_level_full: got %b expected 1", irq_level);
    end
    thresh = '0;
    drain();
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (irq_timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_empty: got %b expected 0 at idle cycle %0d", irq_timeout, k);
      end
    end
    xfer(1'b1, 8'h55, 1'b0);
    for (int k = 1; k <= TOUT; k++) begin
      @(posedge clk); #1;
      checks++;
      if (irq_timeout !== (k == TOUT)) begin
        failures++;
        $display("FAIL timeout_edge: got %b expected %b at %0d cycles after push", irq_timeout, k == TOUT, k);
      end
    end
    xfer(1'b1, 8'h66, 1'b0);
    checks++;
    if (irq_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky_push: got %b expected 1", irq_timeout);
    end
    xfer(1'b0, '0, 1'b1);
    checks++;
    if (irq_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pop_clear: got %b expected 0", irq_timeout);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, WIDTH'(8'h80 + i), 1'b0);
    xfer(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) xfer(1'b0, '0, 1'b1);
    check_state("pre_flush");
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check_state("flush");
    xfer(1'b1, 8'h88, 1'b0);
    for (int k = 0; k < TOUT; k++) begin @(posedge clk); #1; end
    checks++;
    if (irq_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_before_flush: got %b expected 1", irq_timeout);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    checks++;
    if (irq_timeout !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL flush_timeout: got tout=%b count=%0d expected 0 0", irq_timeout, count);
    end
    xfer(1'b1, 8'h99, 1'b0);
    drain(); check_state("post_flush");
  endtask

  task automatic test_reset_mid();
    thresh = CW'(4);
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, WIDTH'(8'hD0 + i), 1'b0);
    xfer(1'b1, 8'hFF, 1'b0);
    check_state("pre_reset");
    #2 rst = 1'b1;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); m_ovr = 1'b0; thresh = '0;
    xfer(1'b1, 8'h5A, 1'b0);
    drain(); check_state("after_reset");
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; pop = 1'b0; flush = 1'b0;
    thresh = '0; clear_overrun = 1'b0; m_ovr = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_ordering();
    test_full_overrun();
    test_back_to_back();
    test_wrap_watermark();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
